itrx_aib_phy_tx_seq: RTL



---
 rtl/itrx_aib_phy_tx_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/itrx_aib_phy_tx_seq.sv
// AIB transmit sequencer: trains the far-side receiver with a clock pattern and marker,
// then streams DDR words from a small FIFO to the IO buffers, retraining on request.
module itrx_aib_phy_tx_seq #(
    parameter int LANES    = 8,
    parameter int MARK_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_en,
    input  logic               train_req,
    input  logic               in_valid,
    input  logic [2*LANES-1:0] in_data,
    output logic               in_ready,
    output logic [LANES-1:0]   idat0,
    output logic [LANES-1:0]   idat1,
    output logic               txen,
    output logic               iddr_enable,
    output logic               link_up,
    output logic               train_done
);

    localparam int CW = (MARK_LEN > 1) ? $clog2(MARK_LEN) : 1;
    localparam logic [CW-1:0] MARK_IDX = CW'(MARK_LEN - 1);

    typedef enum logic [1:0] {OFF, TRAIN, DATA} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [1:0]         count, count_n;
    logic               pend, pend_n;
    logic [2*LANES-1:0] head, tail, head_n, tail_n;
    logic               push, pop;
    logic               ready_n, txen_n, ddr_n, link_n, done_n;
    logic [LANES-1:0]   d0_n, d1_n;

    // Even word bits feed idat0 (first half), odd bits feed idat1; result is {idat1, idat0}.
    function automatic logic [2*LANES-1:0] split(input logic [2*LANES-1:0] w);
        logic [LANES-1:0] e, o;
        for (int i = 0; i < LANES; i++) begin
            e[i] = w[2*i];
            o[i] = w[2*i+1];
        end
        return {o, e};
    endfunction

    assign push = in_valid && in_ready;
    assign pop  = (state == DATA) && (count != 2'd0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        count_n = count;
        pend_n  = pend;
        head_n  = head;
        tail_n  = tail;
        ready_n = 1'b0;
        txen_n  = 1'b0;
        ddr_n   = 1'b0;
        link_n  = 1'b0;
        done_n  = 1'b0;
        d0_n    = '0;
        d1_n    = '0;

        if (!tx_en) begin
            state_n = OFF;
            cnt_n   = '0;
            count_n = 2'd0;
            pend_n  = 1'b0;
        end else begin
            case (state)
                OFF: begin
                    state_n = TRAIN;
                    cnt_n   = '0;
                end
                TRAIN: begin
                    if (cnt == MARK_IDX) begin
                        state_n = DATA;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (pop) {d1_n, d0_n} = split(head);
                    case ({push, pop})
                        2'b10: begin
                            if (count == 2'd0) head_n = in_data;
                            else               tail_n = in_data;
                            count_n = count + 2'd1;
                        end
                        2'b01: begin
                            head_n  = tail;
                            count_n = count - 2'd1;
                        end
                        2'b11: begin
                            if (count == 2'd1) begin
                                head_n = in_data;
                            end else begin
                                head_n = tail;
                                tail_n = in_data;
                            end
                        end
                        default: ;
                    endcase
                    pend_n = pend | train_req;
                    // Retrain only once every queued word has left the FIFO.
                    if (pend && count == 2'd0) begin
                        state_n = TRAIN;
                        cnt_n   = '0;
                        pend_n  = 1'b0;
                    end
                end
                default: state_n = OFF;
            endcase
        end

        case (state_n)
            TRAIN: begin
                txen_n = 1'b1;
                ddr_n  = 1'b1;
                d0_n   = '1;
                d1_n   = (cnt_n == MARK_IDX) ? '1 : '0;
            end
            DATA: begin
                txen_n  = 1'b1;
                ddr_n   = 1'b1;
                link_n  = 1'b1;
                done_n  = (state == TRAIN);
                ready_n = !pend_n && (count_n < 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= OFF;
            cnt         <= '0;
            count       <= 2'd0;
            pend        <= 1'b0;
            in_ready    <= 1'b0;
            idat0       <= '0;
            idat1       <= '0;
            txen        <= 1'b0;
            iddr_enable <= 1'b0;
            link_up     <= 1'b0;
            train_done  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            count       <= count_n;
            pend        <= pend_n;
            in_ready    <= ready_n;
            idat0       <= d0_n;
            idat1       <= d1_n;
            txen        <= txen_n;
            iddr_enable <= ddr_n;
            link_up     <= link_n;
            train_done  <= done_n;
        end
    end

    // FIFO storage carries no reset; occupancy alone marks it valid.
    always_ff @(posedge clk) begin
        head <= head_n;
        tail <= tail_n;
    end

    assert property (@(posedge clk) disable iff (rst) !(push && count == 2'd2));

endmodule
